// File: rtl/fpu_pkg.sv
// Shared definitions for the 32-bit custom float format (1 sign, 6 exponent, 25 mantissa)
// used by the float-to-int converter and the adder.
package fpu_pkg;

  localparam int FP_BIAS   = 31;
  localparam int FP_W      = 32;
  localparam int EXP_W     = 6;
  localparam int MANT_W    = 25;
  localparam int SIGN_POS  = 31;
  localparam int EXP_MSB   = 30;
  localparam int EXP_LSB   = 25;
  localparam int MANT_MSB  = 24;

  localparam logic [3:0] ST_EXACT     = 4'b0001;
  localparam logic [3:0] ST_INEXACT   = 4'b1111;
  localparam logic [3:0] ST_OVERFLOW  = 4'b0011;
  localparam logic [3:0] ST_UNDERFLOW = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_SHIFT = 2'd2,
    S_PACK  = 2'd3
  } cvt_state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp_fields_t;

  function automatic fp_fields_t fp_unpack(input logic [FP_W-1:0] v);
    fp_fields_t f;
    f.sign = v[SIGN_POS];
    f.exp  = v[EXP_MSB:EXP_LSB];
    f.mant = v[MANT_MSB:0];
    return f;
  endfunction

endpackage

// File: rtl/fpu_to_int.sv
// Multi-cycle float-to-signed-int converter: truncates toward zero, saturates on overflow,
// shifting the mantissa one bit per cycle by the unbiased exponent.
module fpu_to_int
  import fpu_pkg::*;
#(
  parameter int BIAS = fpu_pkg::FP_BIAS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] fp_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] int_out,
  output logic [3:0]  status_out
);

  localparam logic signed [7:0] BIAS_S = 8'(BIAS);

  cvt_state_e  state_q, state_d;
  logic [31:0] op_q, op_d;
  logic [56:0] mag_q, mag_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        special_q, special_d;
  logic [31:0] res_int_q, res_int_d;
  logic [3:0]  res_status_q, res_status_d;
  logic [31:0] int_out_q, int_out_d;
  logic [3:0]  status_out_q, status_out_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  fp_fields_t       f_s;
  logic signed [7:0] e_s;

  assign f_s = fp_unpack(op_q);
  assign e_s = $signed({2'b00, f_s.exp}) - BIAS_S;

  // Next-state and datapath: special cases are resolved in CHECK and parked until PACK.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    mag_d        = mag_q;
    cnt_d        = cnt_q;
    special_d    = special_q;
    res_int_d    = res_int_q;
    res_status_d = res_status_q;
    int_out_d    = int_out_q;
    status_out_d = status_out_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = fp_in;
          state_d = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        special_d = 1'b1;
        state_d   = S_PACK;
        if ((f_s.exp == 6'd0) && (f_s.mant == 25'd0)) begin
          res_int_d    = 32'd0;
          res_status_d = ST_EXACT;
        end else if (e_s < 8'sd0) begin
          res_int_d    = 32'd0;
          res_status_d = ST_UNDERFLOW;
        end else if (e_s >= 8'sd31) begin
          if (f_s.sign && (e_s == 8'sd31) && (f_s.mant == 25'd0)) begin
            res_int_d    = 32'h8000_0000;
            res_status_d = ST_EXACT;
          end else begin
            res_int_d    = f_s.sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
            res_status_d = ST_OVERFLOW;
          end
        end else begin
          special_d = 1'b0;
          mag_d     = {31'd0, 1'b1, f_s.mant};
          cnt_d     = e_s[5:0];
          state_d   = (e_s == 8'sd0) ? S_PACK : S_SHIFT;
        end
      end
      S_SHIFT: begin
        mag_d   = {mag_q[55:0], 1'b0};
        cnt_d   = cnt_q - 6'd1;
        state_d = (cnt_q == 6'd1) ? S_PACK : S_SHIFT;
      end
      S_PACK: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (special_q) begin
          int_out_d    = res_int_q;
          status_out_d = res_status_q;
        end else begin
          int_out_d    = f_s.sign ? ((~mag_q[56:25]) + 32'd1) : mag_q[56:25];
          status_out_d = (mag_q[24:0] != 25'd0) ? ST_INEXACT : ST_EXACT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any conversion in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      op_q         <= 32'd0;
      mag_q        <= 57'd0;
      cnt_q        <= 6'd0;
      special_q    <= 1'b0;
      res_int_q    <= 32'd0;
      res_status_q <= 4'd0;
      int_out_q    <= 32'd0;
      status_out_q <= 4'd0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      mag_q        <= mag_d;
      cnt_q        <= cnt_d;
      special_q    <= special_d;
      res_int_q    <= res_int_d;
      res_status_q <= res_status_d;
      int_out_q    <= int_out_d;
      status_out_q <= status_out_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign int_out    = int_out_q;
  assign status_out = status_out_q;

endmodule

// File: tb/tb_fpu_to_int.sv
// Directed self-checking bench for fpu_to_int: hand-computed results, status codes and latencies.
module tb_fpu_to_int;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] fp_in;
  logic        busy;
  logic        done;
  logic [31:0] int_out;
  logic [3:0]  status_out;

  int n_cmp;
  int n_err;

  fpu_to_int #(.BIAS(31)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .fp_in(fp_in),
    .busy(busy),
    .done(done),
    .int_out(int_out),
    .status_out(status_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Launch one conversion from the current point (#1 after a rising edge) and count edges,
  // accepting edge included, until done is seen high; gives up at 100.
  task automatic run_op(input logic [31:0] op, output int lat);
    fp_in = op;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    fp_in = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if ({busy, done, int_out, status_out} !== 38'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b int=%h st=%b, want all 0", busy, done, int_out, status_out);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_exact_one();
    int lat;
    run_op(32'h3E00_0000, lat);
    n_cmp++;
    if (int_out !== 32'h0000_0001 || status_out !== 4'b0001) begin
      n_err++;
      $display("FAIL one_result: got %h/%b, want 00000001/0001", int_out, status_out);
    end
    n_cmp++;
    if (lat !== 3) begin
      n_err++;
      $display("FAIL one_latency: got %0d, want 3", lat);
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || int_out !== 32'h0000_0001) begin
      n_err++;
      $display("FAIL one_hold: got done=%b busy=%b int=%h, want 0/0/00000001", done, busy, int_out);
    end
  endtask

  task automatic test_inexact();
    int lat;
    run_op(32'h4080_0000, lat);
    n_cmp++;
    if (int_out !== 32'h0000_0002 || status_out !== 4'b1111) begin
      n_err++;
      $display("FAIL inexact_result: got %h/%b, want 00000002/1111", int_out, status_out);
    end
    n_cmp++;
    if (lat !== 4) begin
      n_err++;
      $display("FAIL inexact_latency: got %0d, want 4", lat);
    end
  endtask

  task automatic test_negative_busy();
    int lat;
    fp_in = 32'hC400_0000;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    lat = 1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL neg_busy: got %b, want 1", busy);
    end
    fp_in = 32'h7E00_0000;
    start = 1'b1;
    @(posedge clock);
    #1;
    lat++;
    @(posedge clock);
    #1;
    lat++;
    start = 1'b0;
    while (!done && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    n_cmp++;
    if (int_out !== 32'hFFFF_FFF8 || status_out !== 4'b0001) begin
      n_err++;
      $display("FAIL neg_result: got %h/%b, want fffffff8/0001", int_out, status_out);
    end
    n_cmp++;
    if (lat !== 6) begin
      n_err++;
      $display("FAIL neg_latency: got %0d, want 6", lat);
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL neg_ignored_start: got busy=%b done=%b, want 0/0", busy, done);
    end
  endtask

  task automatic test_underflow_zero();
    int lat;
    run_op(32'h3C00_0000, lat);
    n_cmp++;
    if (int_out !== 32'h0 || status_out !== 4'b0111 || lat !== 3) begin
      n_err++;
      $display("FAIL underflow: got %h/%b lat %0d, want 00000000/0111 lat 3", int_out, status_out, lat);
    end
    run_op(32'h4080_0000, lat);
    run_op(32'h0000_0000, lat);
    n_cmp++;
    if (int_out !== 32'h0 || status_out !== 4'b0001 || lat !== 3) begin
      n_err++;
      $display("FAIL zero: got %h/%b lat %0d, want 00000000/0001 lat 3", int_out, status_out, lat);
    end
  endtask

  task automatic test_overflow();
    int lat;
    run_op(32'h7E00_0000, lat);
    n_cmp++;
    if (int_out !== 32'h7FFF_FFFF || status_out !== 4'b0011 || lat !== 3) begin
      n_err++;
      $display("FAIL overflow_pos: got %h/%b lat %0d, want 7fffffff/0011 lat 3", int_out, status_out, lat);
    end
    run_op(32'hFC00_0000, lat);
    n_cmp++;
    if (int_out !== 32'h8000_0000 || status_out !== 4'b0001 || lat !== 3) begin
      n_err++;
      $display("FAIL min_int: got %h/%b lat %0d, want 80000000/0001 lat 3", int_out, status_out, lat);
    end
    run_op(32'hFE00_0000, lat);
    n_cmp++;
    if (int_out !== 32'h8000_0000 || status_out !== 4'b0011) begin
      n_err++;
      $display("FAIL overflow_neg: got %h/%b, want 80000000/0011", int_out, status_out);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(32'h4080_0000, lat);
    run_op(32'hC400_0000, lat);
    n_cmp++;
    if (int_out !== 32'hFFFF_FFF8 || status_out !== 4'b0001 || lat !== 6) begin
      n_err++;
      $display("FAIL back_to_back: got %h/%b lat %0d, want fffffff8/0001 lat 6", int_out, status_out, lat);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen_done;
    fp_in = 32'h4A00_0000;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, int_out, status_out} !== 38'd0) begin
      n_err++;
      $display("FAIL abort_outputs: got busy=%b done=%b int=%h st=%b, want all 0", busy, done, int_out, status_out);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    seen_done = 0;
    repeat (10) begin
      @(posedge clock);
      #1;
      if (done) seen_done++;
    end
    n_cmp++;
    if (seen_done !== 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_no_done: got %0d done pulses busy=%b, want 0/0", seen_done, busy);
    end
    run_op(32'h3E00_0000, lat);
    n_cmp++;
    if (int_out !== 32'h0000_0001 || status_out !== 4'b0001 || lat !== 3) begin
      n_err++;
      $display("FAIL abort_recover: got %h/%b lat %0d, want 00000001/0001 lat 3", int_out, status_out, lat);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_exact_one();
    test_inexact();
    test_negative_busy();
    test_underflow_zero();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_to_int.md
FPU_TO_INT -- requirements
Module: fpu_to_int

Interface
REQ-001 SHALL have parameter BIAS, default 31: exponent bias of the 32-bit custom float format (1 sign, 6 exponent, 25 mantissa bits).
REQ-002 SHALL have ports: clock  in  1  system clock, rising-edge active.
REQ-003 SHALL have ports: reset  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: start  in  1  request to convert fp_in; sampled only in IDLE.
REQ-005 SHALL have ports: fp_in  in  32  operand, [31] sign, [30:25] biased exponent, [24:0] mantissa with implicit leading 1.
REQ-006 SHALL have ports: busy  out  1  high in every state except IDLE.
REQ-007 SHALL have ports: done  out  1  one-cycle pulse when int_out/status_out are updated.
REQ-008 SHALL have ports: int_out  out  32  two's-complement signed integer result, held until the next done.
REQ-009 SHALL have ports: status_out  out  4  0001 exact, 1111 inexact, 0011 overflow, 0111 underflow; held until the next done.

Function
REQ-010 SHALL implement FSM states IDLE, CHECK, SHIFT, PACK.
REQ-011 SHALL, in IDLE with start=1, capture fp_in at the clock edge and go to CHECK; start=0 stays in IDLE.
REQ-012 SHALL ignore start while busy=1; the captured operand stays unchanged.
REQ-013 SHALL, in CHECK, compute unbiased e = exp_field - BIAS, range -31..32.
REQ-014 SHALL treat exp_field=0 and mantissa=0 as zero, either sign: result 0, status 0001, CHECK->PACK.
REQ-015 SHALL treat any other operand with e<0 as underflow: result 0, status 0111, CHECK->PACK.
REQ-016 SHALL treat e>=31 as overflow: result 0x7FFFFFFF (positive) or 0x80000000 (negative), status 0011, CHECK->PACK.
REQ-017 SHALL treat sign=1, e=31, mantissa=0 as exactly -2^31: result 0x80000000, status 0001.
REQ-018 SHALL, for 0<=e<=30, use a 57-bit magnitude register loaded with {31'b0, 1'b1, mantissa}; [56:25] is the integer part, [24:0] the fraction.
REQ-019 SHALL, for those operands, load a shift counter with e; SHIFT shifts the magnitude left by 1 and decrements the counter each cycle, going to PACK when the counter reaches 0.
REQ-020 SHALL go CHECK->PACK directly when e=0.
REQ-021 SHALL, in PACK, truncate toward zero: integer = magnitude[56:25], negated (two's complement) when sign=1.
REQ-022 SHALL report status 1111 when magnitude[24:0] is nonzero at PACK, otherwise 0001.
REQ-023 SHALL, at the PACK edge, register int_out and status_out, assert done for exactly one cycle, and return to IDLE.
REQ-024 SHALL have a latency, from the start-accepting edge to done high, of 3 cycles for special cases and e=0, and e+3 cycles otherwise.
REQ-025 SHALL accept start in the same cycle that done is high, since the FSM is already in IDLE.

Reset
REQ-026 SHALL, while reset=0, force: state IDLE, busy=0, done=0, int_out=0, status_out=0000, internal registers 0.
REQ-027 SHALL, on reset asserted mid-conversion, abort the conversion with no done pulse; the first start after release is converted normally.

Structure
REQ-028 SHALL take BIAS, field widths/positions, the four status codes and the state enum type from shared package fpu_pkg, which the adder also uses.
REQ-029 SHALL be a single module with no sub-modules; field extraction is a function in fpu_pkg.

Verification
REQ-030 SHALL check: fp_in=0x3E000000 (1.0) -> int_out=0x00000001, status 0001, done 3 cycles after start.
REQ-031 SHALL check: fp_in=0x40800000 (2.5) -> int_out=0x00000002, status 1111, done 4 cycles after start.
REQ-032 SHALL check: fp_in=0xC4000000 (-8.0) -> int_out=0xFFFFFFF8, status 0001, done 6 cycles after start; start pulsed during busy is ignored.
REQ-033 SHALL check: fp_in=0x3C000000 (0.5) -> 0x00000000, status 0111; fp_in=0x00000000 -> 0x00000000, status 0001.
REQ-034 SHALL check: fp_in=0x7E000000 -> 0x7FFFFFFF, status 0011; fp_in=0xFC000000 (-2^31) -> 0x80000000, status 0001.
REQ-035 SHALL check: reset asserted during SHIFT of 0x4A000000 -> all outputs 0, no done; after release, start with 0x3E000000 -> 0x00000001.
